// File: rtl/resgen_luma16x16.sv
// resgen_luma16x16 - Intra 16x16 luma residual generator.
// Captures an original 16x16 block plus its top/left neighbours, computes
// the DC predictor, then writes vertical, horizontal and DC residuals one
// row (16 samples per mode) per cycle. Latency start->done is 18 cycles.
// Optional build macro: RESGEN_SAT_EN
//   defined   : each 9-bit difference saturates to [-128, 127]
//   undefined : each difference wraps to its low 8 bits (default)
module resgen_luma16x16 (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [255:0][7:0]         orig,
  input  logic [15:0][7:0]          top,
  input  logic [15:0][7:0]          left,
  input  logic                      top_avail,
  input  logic                      left_avail,
  output logic signed [255:0][7:0]  vres,
  output logic signed [255:0][7:0]  hres,
  output logic signed [255:0][7:0]  dcres,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, DCCALC, ROWS, DONE} state_t;

  state_t            state_q, state_d;
  logic              capture;
  logic [3:0]        r_q;
  logic [7:0]        dc_q, dc_d;

  logic [255:0][7:0] orig_q;
  logic [15:0][7:0]  top_q, left_q;
  logic              tav_q, lav_q;

  logic [11:0]       st, sl;
  logic [12:0]       sum_both;
  logic [15:0][7:0]  vrow, hrow, dcrow;

  // Residual of one sample against its predictor, narrowed to 8 bits.
  function automatic logic [7:0] resid(input logic [7:0] a, input logic [7:0] b);
`ifdef RESGEN_SAT_EN
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d > 9'sd127)
      resid = 8'h7f;
    else if (d < -9'sd128)
      resid = 8'h80;
    else
      resid = d[7:0];
`else
    resid = a - b;
`endif
  endfunction

  // Next-state logic; capture fires only for a start seen in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = DCCALC;
        end
      end
      DCCALC: state_d = ROWS;
      ROWS:   if (r_q == 4'd15) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input snapshot; contents are don't-care until the first capture.
  always_ff @(posedge clk) begin
    // NOTE: the captured block is pure data storage, so it carries no reset; only control and outputs are reset.
    if (capture) begin
      orig_q <= orig;
      top_q  <= top;
      left_q <= left;
      tav_q  <= top_avail;
      lav_q  <= left_avail;
    end
  end

  // DC predictor from the neighbour sums, selected by availability.
  always_comb begin
    st = '0;
    sl = '0;
    for (int c = 0; c < 16; c++) begin
      st = st + 12'(top_q[c]);
      sl = sl + 12'(left_q[c]);
    end
    sum_both = 13'(st) + 13'(sl) + 13'd16;
    case ({tav_q, lav_q})
      2'b11:   dc_d = 8'(sum_both >> 5);
      2'b10:   dc_d = 8'((st + 12'd8) >> 4);
      2'b01:   dc_d = 8'((sl + 12'd8) >> 4);
      default: dc_d = 8'd128;
    endcase
  end

  // Residuals for the current row r_q, all 16 columns in parallel.
  always_comb begin
    for (int c = 0; c < 16; c++) begin
      vrow[c]  = resid(orig_q[{r_q, 4'(c)}], tav_q ? top_q[c] : 8'd128);
      hrow[c]  = resid(orig_q[{r_q, 4'(c)}], lav_q ? left_q[r_q] : 8'd128);
      dcrow[c] = resid(orig_q[{r_q, 4'(c)}], dc_q);
    end
  end

  // Control state, registered handshake outputs and row write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      dc_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vres    <= '0;
      hres    <= '0;
      dcres   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      if (state_q == DCCALC) begin
        dc_q <= dc_d;
        r_q  <= '0;
      end
      if (state_q == ROWS) begin
        r_q <= r_q + 4'd1;
        for (int c = 0; c < 16; c++) begin
          vres[{r_q, 4'(c)}]  <= vrow[c];
          hres[{r_q, 4'(c)}]  <= hrow[c];
          dcres[{r_q, 4'(c)}] <= dcrow[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_resgen_luma16x16.sv
// Directed bench for resgen_luma16x16: flat-block vector table, row/column
// mapping, start handshake and mid-block reset sequences.
module tb_resgen_luma16x16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [255:0][7:0]        orig;
  logic [15:0][7:0]         top;
  logic [15:0][7:0]         left;
  logic                     top_avail;
  logic                     left_avail;
  logic signed [255:0][7:0] vres;
  logic signed [255:0][7:0] hres;
  logic signed [255:0][7:0] dcres;
  logic                     busy;
  logic                     done;

  int n_checks = 0;
  int n_fail   = 0;

  resgen_luma16x16 dut (
    .clk(clk), .reset(reset), .start(start),
    .orig(orig), .top(top), .left(left),
    .top_avail(top_avail), .left_avail(left_avail),
    .vres(vres), .hres(hres), .dcres(dcres),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] o, t, l;
    logic       tav, lav;
    logic [7:0] ev, eh, edc;
  } vec_t;

  vec_t vecs [6];
  logic [255:0][7:0] exp_v, exp_h, exp_dc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_arr(input string name, input logic [255:0][7:0] act,
                           input logic [255:0][7:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = 255; i >= 0; i--)
      if (act[i] !== exp[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: element %0d got %02h, expected %02h", name, bad, act[bad], exp[bad]);
    end
  endtask

  // Expected 8-bit residual for a mathematical difference d.
  function automatic logic [7:0] fitb(input int d);
`ifdef RESGEN_SAT_EN
    if (d > 127) return 8'h7f;
    if (d < -128) return 8'h80;
`endif
    return 8'(d);
  endfunction

  task automatic fill_flat(input vec_t v);
    for (int i = 0; i < 256; i++) orig[i] = v.o;
    for (int i = 0; i < 16; i++) begin
      top[i]  = v.t;
      left[i] = v.l;
    end
    top_avail  = v.tav;
    left_avail = v.lav;
  endtask

  // Pulse start, scramble inputs afterwards, wait (bounded) for done.
  // Returns the cycle number at which done was seen (cycle 1 = after start edge).
  task automatic run_block(output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    orig       = ~orig;
    top        = ~top;
    left       = ~left;
    top_avail  = ~top_avail;
    left_avail = ~left_avail;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  int cyc, ndone, first_d, second_d;
  logic busy19, busy20;

  initial begin
    // Flat-block table: orig, top, left, tav, lav, exp vres, hres, dcres.
    vecs[0] = '{8'd100, 8'd90, 8'd110, 1'b1, 1'b1, 8'd10,  8'hf6, 8'd0};
    vecs[1] = '{8'd100, 8'd90, 8'd110, 1'b0, 1'b1, 8'he4, 8'hf6, 8'hf6};
    vecs[2] = '{8'd100, 8'd90, 8'd110, 1'b1, 1'b0, 8'd10,  8'he4, 8'd10};
    vecs[3] = '{8'd100, 8'd90, 8'd110, 1'b0, 1'b0, 8'he4, 8'he4, 8'he4};
`ifdef RESGEN_SAT_EN
    vecs[4] = '{8'd255, 8'd0,   8'd0,   1'b1, 1'b1, 8'h7f, 8'h7f, 8'h7f};
    vecs[5] = '{8'd0,   8'd255, 8'd255, 1'b1, 1'b1, 8'h80, 8'h80, 8'h80};
`else
    vecs[4] = '{8'd255, 8'd0,   8'd0,   1'b1, 1'b1, 8'hff, 8'hff, 8'hff};
    vecs[5] = '{8'd0,   8'd255, 8'd255, 1'b1, 1'b1, 8'h01, 8'h01, 8'h01};
`endif

    reset = 1'b1;
    start = 1'b0;
    fill_flat(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check_arr("reset_vres", vres, '0);
    check_arr("reset_hres", hres, '0);
    check_arr("reset_dcres", dcres, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven flat blocks.
    for (int k = 0; k < 6; k++) begin
      fill_flat(vecs[k]);
      run_block(cyc);
      check($sformatf("vec%0d_latency", k), cyc, 18);
      check($sformatf("vec%0d_busy_at_done", k), busy, 1'b1);
      for (int i = 0; i < 256; i++) begin
        exp_v[i]  = vecs[k].ev;
        exp_h[i]  = vecs[k].eh;
        exp_dc[i] = vecs[k].edc;
      end
      check_arr($sformatf("vec%0d_vres", k), vres, exp_v);
      check_arr($sformatf("vec%0d_hres", k), hres, exp_h);
      check_arr($sformatf("vec%0d_dcres", k), dcres, exp_dc);
      @(posedge clk); #1;
    end

    // Row/column mapping: orig[i]=i, top[c]=c, left[r]=16r, dc=64.
    for (int i = 0; i < 256; i++) orig[i] = 8'(i);
    for (int i = 0; i < 16; i++) begin
      top[i]  = 8'(i);
      left[i] = 8'(16 * i);
    end
    top_avail  = 1'b1;
    left_avail = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_v[i]  = fitb(16 * (i / 16));
      exp_h[i]  = fitb(i % 16);
      exp_dc[i] = fitb(i - 64);
    end
    run_block(cyc);
    check("map_latency", cyc, 18);
    check_arr("map_vres", vres, exp_v);
    check_arr("map_hres", hres, exp_h);
    check_arr("map_dcres", dcres, exp_dc);
    check("map_dcres37", dcres[37], 8'he5);
    @(posedge clk); #1;

    // Handshake: starts in cycles 5 and 18 ignored, cycle 19 accepted.
    fill_flat(vecs[0]);
    start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first_d = 0; second_d = 0; busy19 = 1'bx; busy20 = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5 || c == 18 || c == 19);
      if (done) begin
        ndone++;
        if (first_d == 0) first_d = c;
        else second_d = c;
      end
      if (c == 19) busy19 = busy;
      if (c == 20) busy20 = busy;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("hs_done_count", ndone, 2);
    check("hs_first_done", first_d, 18);
    check("hs_second_done", second_d, 37);
    check("hs_busy_c19", busy19, 1'b0);
    check("hs_busy_c20", busy20, 1'b1);

    // Mid-block reset in cycle 10, then a clean block.
    fill_flat(vecs[2]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check_arr("rst_mid_vres", vres, '0);
    check_arr("rst_mid_hres", hres, '0);
    check_arr("rst_mid_dcres", dcres, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("rst_no_done", ndone, 0);
    fill_flat(vecs[0]);
    run_block(cyc);
    check("rst_after_latency", cyc, 18);
    for (int i = 0; i < 256; i++) exp_v[i] = 8'd10;
    check_arr("rst_after_vres", vres, exp_v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/resgen_luma16x16.md
# resgen_luma16x16

Residual generator for Intra 16x16 luma prediction. It captures one 16x16 original block together with its top and left neighbour samples. It then builds the vertical, horizontal and DC predictions and writes the three signed 8-bit residual arrays row by row. The block sits directly upstream of the 16x16 SAD stage: its `done` pulse drives that stage's `enable`, and its `vres`/`hres`/`dcres` arrays are the SAD stage's inputs.

## Interface
- No parameters; the block size is fixed at 16x16, 8-bit samples.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  1-cycle request; sampled only in IDLE.
- `orig`  in  8 x [255:0]  unsigned original pixels, row-major, index = 16*row + col.
- `top`  in  8 x [15:0]  unsigned row above the block, index = col.
- `left`  in  8 x [15:0]  unsigned column left of the block, index = row.
- `top_avail`  in  1  top neighbours valid.
- `left_avail`  in  1  left neighbours valid.
- `vres`  out  signed 8 x [255:0]  vertical-mode residuals.
- `hres`  out  signed 8 x [255:0]  horizontal-mode residuals.
- `dcres`  out  signed 8 x [255:0]  DC-mode residuals.
- `busy`  out  1  high from the cycle after an accepted start until `done`, inclusive.
- `done`  out  1  1-cycle pulse; all 768 residuals are valid and stable.

## Operation
- FSM states: IDLE, DCCALC, ROWS, DONE.
- IDLE: on `start`=1, latch `orig`, `top`, `left`, `top_avail` and `left_avail` into internal registers, then go to DCCALC. Inputs may change freely after the start cycle.
- DCCALC (1 cycle): compute the DC value `dc` from the latched data. ST = sum of `top`, SL = sum of `left`, both 12-bit unsigned.
  - both available: `dc` = (ST+SL+16)>>5
  - top only: `dc` = (ST+8)>>4
  - left only: `dc` = (SL+8)>>4
  - neither: `dc` = 128
- After DCCALC, clear row counter `r` to 0 and go to ROWS.
- ROWS (16 cycles): for row `r` and all 16 columns `c` in parallel, with i = 16r+c:
  - vres[i] = orig[i] − (top_avail ? top[c] : 128)
  - hres[i] = orig[i] − (left_avail ? left[r] : 128)
  - dcres[i] = orig[i] − `dc`
  - Subtraction is 9-bit signed (−255..255) before the width rule in Configuration.
  - `r` increments each cycle; after row 15, go to DONE.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Output rows are overwritten only in ROWS. Rows not yet written hold the previous block's values, so the outputs are valid only when `done` is high and until the next start's ROWS phase.
- Reset values: all residual outputs 0, `busy`=0, `done`=0, FSM in IDLE, `r`=0.
- Reset asserted mid-operation: the above values apply immediately (asynchronous). The partial block is discarded and no `done` is issued.

## Timing
- `start` sampled high at edge 0 → DCCALC in cycle 1 → ROWS in cycles 2–17 (row r written at edge r+2) → `done` high in cycle 18.
- Latency from start to done: 18 cycles. Maximum throughput: one block per 19 cycles, since a new `start` is accepted in the cycle after `done`.
- `busy` is high in cycles 1–18.
- `done` and `busy` are registered outputs.

## Configuration
- `RESGEN_SAT_EN` defined: each 9-bit difference saturates to [−128, 127].
- `RESGEN_SAT_EN` undefined: each difference is truncated to its low 8 bits (two's-complement wrap). This matches the SAD stage's raw 8-bit behaviour and is cheaper.

## Test plan
- Flat block: orig all 100, top all 90, left all 110, both available, start → at done: vres all 10, hres all −10, `dc`=100 so dcres all 0; `done` exactly at cycle 18.
- Availability: same data with top_avail=0, left_avail=1 → vres all −28, `dc`=110, dcres all −10. With neither available → `dc`=128, all three arrays −28.
- Saturation: orig all 255, top all 0, left all 0, both available. With `RESGEN_SAT_EN` → vres = hres = dcres = 127 everywhere. Without it → 255 wraps to −1 in all three arrays.
- Row/column mapping: orig[i]=i mod 256, top[c]=c, left[r]=16r, both available → vres[i]=16r, hres[i]=c, dcres[37] = 37 − `dc` where `dc` = (120+1920+16)>>5 = 64, so dcres[37] = −27.
- Handshake: pulse `start` again in cycles 5 and 18 → both ignored; `done` pulses once. A `start` in cycle 19 is accepted and the next `done` arrives at cycle 37.
- Reset in cycle 10 → outputs are 0 and `busy` drops immediately; no `done`; a following `start` completes normally after 18 cycles.
